// File: rtl/pong_game_sequencer.sv
// Game-level sequencer for the paddle/ball design: walks through idle, serve,
// play and game-over phases, gates the divided movement enable to the widgets,
// detects a ball miss past the paddle line, keeps a BCD hit score and counts lives.
module pong_game_sequencer #(
    parameter int unsigned LIVES       = 3,    // lives loaded at game start (1..3)
    parameter int unsigned SERVE_TICKS = 60,   // unpaused ticks held before a serve (1..255)
    parameter int unsigned MISS_X      = 780   // right edge beyond this x is a miss
) (
    input  logic               CLK_100MHz,
    input  logic               Reset,
    input  logic               tick,
    input  logic               start,
    input  logic               pause,
    input  logic signed [10:0] ballX,
    input  logic        [8:0]  ballSizeX,
    input  logic               hit,
    output logic               widgetEn,
    output logic               ballLoad,
    output logic        [7:0]  score,
    output logic        [1:0]  lives,
    output logic        [1:0]  state,
    output logic               gameOver
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StServe = 2'd1,
        StPlay  = 2'd2,
        StOver  = 2'd3
    } game_state_e;

    localparam logic [1:0]         LivesInit = 2'(LIVES);
    localparam logic [7:0]         ServeInit = 8'(SERVE_TICKS);
    localparam logic signed [11:0] MissLimit = 12'(MISS_X);

    game_state_e state_q, state_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        load_q, load_d;
    logic        start_prev_q;

    logic               start_edge;
    logic               move;
    logic signed [11:0] reach;
    logic               miss;

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // start_prev_q resets high so a button held through reset gives no edge.
    assign start_edge = start & ~start_prev_q;
    assign move       = tick & ~pause;

    // Right edge of the ball in 12-bit signed arithmetic; a negative left edge never misses.
    assign reach = {ballX[10], ballX} + $signed({3'b000, ballSizeX});
    assign miss  = move && !ballX[10] && (reach > MissLimit);

    // Movement reaches the widgets only during play, on the tick cycle itself.
    always_comb begin
        widgetEn = (state_q == StPlay) & move;
    end

    // Next-state logic for phase, score, lives, serve counter and reload pulse.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        unique case (state_q)
            StIdle, StOver: begin
                if (start_edge) begin
                    state_d = StServe;
                    score_d = 8'h00;
                    lives_d = LivesInit;
                    cnt_d   = ServeInit;
                    load_d  = 1'b1;
                end
            end
            StServe: begin
                if (move) begin
                    if (cnt_q == 8'd1) begin
                        state_d = StPlay;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            StPlay: begin
                // A miss wins over a coincident hit.
                if (miss) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        state_d = StServe;
                        cnt_d   = ServeInit;
                        load_d  = 1'b1;
                    end else begin
                        lives_d = 2'd0;
                        state_d = StOver;
                    end
                end else if (hit) begin
                    score_d = bcd_inc(score_q);
                end
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            state_q      <= StIdle;
            score_q      <= 8'h00;
            lives_q      <= LivesInit;
            cnt_q        <= 8'd0;
            load_q       <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
            load_q       <= load_d;
            start_prev_q <= start;
        end
    end

    // Registered outputs for the overlay and widgets.
    always_comb begin
        ballLoad = load_q;
        score    = score_q;
        lives    = lives_q;
        state    = state_q;
        gameOver = (state_q == StOver);
    end

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Randomized and directed bench for pong_game_sequencer against a phase-level game model.
module tb_pong_game_sequencer;

    localparam int unsigned LIVES       = 3;
    localparam int unsigned SERVE_TICKS = 3;
    localparam int unsigned MISS_X      = 780;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               tick = 1'b0;
    logic               start = 1'b0;
    logic               pause = 1'b0;
    logic signed [10:0] ball_x = '0;
    logic        [8:0]  ball_size = '0;
    logic               hit = 1'b0;
    logic               widget_en;
    logic               ball_load;
    logic        [7:0]  score;
    logic        [1:0]  lives;
    logic        [1:0]  state;
    logic               game_over;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 idle, 1 serve, 2 play, 3 over; score kept as a decimal integer.
    int m_phase = 0;
    int m_score = 0;
    int m_lives = LIVES;
    int m_left  = 0;
    bit m_load  = 0;
    bit m_prev  = 1;

    pong_game_sequencer #(
        .LIVES      (LIVES),
        .SERVE_TICKS(SERVE_TICKS),
        .MISS_X     (MISS_X)
    ) dut (
        .CLK_100MHz(clk),
        .Reset     (rst),
        .tick      (tick),
        .start     (start),
        .pause     (pause),
        .ballX     (ball_x),
        .ballSizeX (ball_size),
        .hit       (hit),
        .widgetEn  (widget_en),
        .ballLoad  (ball_load),
        .score     (score),
        .lives     (lives),
        .state     (state),
        .gameOver  (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    // Advance the game model by one clock edge using the inputs held this cycle.
    task automatic model_step(input bit r, input bit st, input bit tk, input bit ps,
                              input bit ht, input int bx, input int bs);
        bit go;
        bit missed;
        if (r) begin
            m_phase = 0; m_score = 0; m_lives = LIVES; m_left = 0; m_load = 0; m_prev = 1;
            return;
        end
        go     = tk && !ps;
        missed = 0;
        m_load = 0;
        if (m_phase == 0 || m_phase == 3) begin
            if (st && !m_prev) begin
                m_phase = 1; m_score = 0; m_lives = LIVES; m_left = SERVE_TICKS; m_load = 1;
            end
        end else if (m_phase == 1) begin
            if (go) begin
                if (m_left == 1) m_phase = 2;
                else m_left--;
            end
        end else begin
            missed = go && (bx >= 0) && (bx + bs > int'(MISS_X));
            if (missed) begin
                if (m_lives > 1) begin
                    m_lives--; m_phase = 1; m_left = SERVE_TICKS; m_load = 1;
                end else begin
                    m_lives = 0; m_phase = 3;
                end
            end else if (ht && m_score < 99) begin
                m_score++;
            end
        end
        m_prev = st;
    endtask

    // One clock cycle: drive, check the combinational enable, clock, check registered outputs.
    task automatic cycle(input bit r, input bit st, input bit tk, input bit ps,
                         input bit ht, input int bx, input int bs);
        bit exp_we;
        rst = r; start = st; tick = tk; pause = ps; hit = ht;
        ball_x = 11'(bx); ball_size = 9'(bs);
        exp_we = (m_phase == 2) && tk && !ps;
        @(negedge clk);
        check("widgetEn", 32'(widget_en), 32'(exp_we));
        @(posedge clk);
        model_step(r, st, tk, ps, ht, bx, bs);
        #1;
        check("ballLoad", 32'(ball_load), 32'(m_load));
        check("state", 32'(state), 32'(m_phase));
        check("score", 32'(score), 32'(to_bcd(m_score)));
        check("lives", 32'(lives), 32'(m_lives));
        check("gameOver", 32'(game_over), 32'(m_phase == 3));
    endtask

    task automatic serve_out();
        for (int i = 0; i < int'(SERVE_TICKS); i++) cycle(0, 0, 1, 0, 0, 100, 10);
    endtask

    initial begin
        // Reset with start held: no edge afterwards while it stays high.
        cycle(1, 1, 0, 0, 0, 100, 10);
        cycle(1, 1, 0, 0, 0, 100, 10);
        cycle(0, 1, 0, 0, 0, 100, 10);
        cycle(0, 1, 0, 0, 0, 100, 10);
        check("held_start_idle", 32'(state), 32'd0);
        cycle(0, 0, 0, 0, 0, 100, 10);
        cycle(0, 1, 0, 0, 0, 100, 10);
        check("fresh_press_load", 32'(ball_load), 32'd1);
        cycle(0, 0, 0, 0, 0, 100, 10);
        // Serve hold with a paused tick in the middle.
        cycle(0, 0, 1, 0, 0, 100, 10);
        cycle(0, 0, 1, 1, 0, 100, 10);
        cycle(0, 0, 1, 0, 0, 100, 10);
        check("still_serve", 32'(state), 32'd1);
        cycle(0, 0, 1, 0, 0, 100, 10);
        check("now_play", 32'(state), 32'd2);
        // Score: 10 hits, then up to 98, then 2 more saturating at 99.
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 100, 10);
        check("score_ten", 32'(score), 32'h10);
        for (int i = 0; i < 88; i++) cycle(0, 0, 0, 0, 1, 100, 10);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 1, 100, 10);
        check("score_sat", 32'(score), 32'h99);
        // Miss boundary cases.
        cycle(0, 0, 1, 0, 0, -5, 500);
        cycle(0, 0, 1, 0, 0, 766, 14);
        check("sum_780_no_miss", 32'(lives), 32'd3);
        cycle(0, 0, 1, 0, 0, 770, 14);
        check("miss_lives", 32'(lives), 32'd2);
        serve_out();
        // Hit and miss together: miss wins.
        cycle(0, 0, 1, 0, 1, 770, 14);
        check("hit_miss_score", 32'(score), 32'h99);
        serve_out();
        cycle(0, 0, 1, 0, 0, 900, 100);
        check("game_over", 32'(game_over), 32'd1);
        cycle(0, 0, 1, 0, 1, 900, 100);
        cycle(0, 1, 0, 0, 0, 100, 10);
        check("restart_lives", 32'(lives), 32'd3);
        serve_out();
        cycle(1, 0, 1, 0, 1, 100, 10);
        check("midgame_reset", 32'(state), 32'd0);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            int bx;
            bx = ($urandom_range(0, 9) == 0) ? -int'($urandom_range(1, 60))
                                             : int'($urandom_range(550, 1023));
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0,
                  bx, int'($urandom_range(0, 250)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pong_game_sequencer.md
# pong_game_sequencer

Game-level controller for the VGA paddle/ball design. It sequences play through idle, serve, play and game-over phases, and gates the divided movement enable (the clock-divider pulse) to the ball and paddle widgets. It detects a ball miss past the paddle line, keeps a two-digit BCD score of paddle hits, and tracks remaining lives. It sits between the clock divider and the widgets; its score, lives and state outputs feed the VGA client for overlay drawing.

## Interface
- LIVES, 3: lives loaded at game start (1..3).
- SERVE_TICKS, 60: movement ticks the ball is held before each serve (1..255).
- MISS_X, 780: x coordinate the ball's right edge must exceed to count as a miss.
- CLK_100MHz  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle movement pulse from the clock divider.
- start  in  1  start button level; rising edge detected internally.
- pause  in  1  pause switch level.
- ballX  in  11 signed  ball left-edge x position.
- ballSizeX  in  9  ball width.
- hit  in  1  one-cycle pulse when the ball bounces off the paddle.
- widgetEn  out  1  gated movement enable to the widgets.
- ballLoad  out  1  one-cycle pulse; widgets reload firstX/firstY.
- score  out  8  BCD score: [7:4] tens, [3:0] units.
- lives  out  2  remaining lives.
- state  out  2  0=IDLE, 1=SERVE, 2=PLAY, 3=OVER.
- gameOver  out  1  high while in OVER.

## Operation
- startEdge = start & ~start_d. start_d is a register that resets to 1, so a button held through reset produces no edge.
- **IDLE**
  - widgetEn=0.
  - On startEdge: go to SERVE; score=0, lives=LIVES, serve counter=SERVE_TICKS, pulse ballLoad.
- **SERVE**
  - widgetEn=0.
  - On tick & ~pause: decrement the counter. If tick & ~pause arrives with the counter already at 1, go to PLAY instead.
  - While pause is high, the counter is frozen.
- **PLAY**
  - widgetEn = tick & ~pause (combinational, same cycle as tick).
  - Miss check runs only on cycles with tick & ~pause: miss = ballX + ballSizeX > MISS_X.
    - Evaluate in 12-bit signed arithmetic: ballX sign-extended, ballSizeX zero-extended.
    - Negative ballX never misses.
  - On miss with lives>1: lives decrements, go to SERVE, reload the counter, pulse ballLoad.
  - On miss with lives==1: lives=0, go to OVER.
  - On hit without a miss: score increments in BCD (09→10, 99 saturates at 99).
  - hit and miss in the same cycle: the miss is taken and the hit is ignored.
  - hit arriving in IDLE, SERVE or OVER is ignored.
- **OVER**
  - gameOver=1, widgetEn=0; score and lives are held for display.
  - On startEdge: same actions as IDLE→SERVE.
- pause has no effect in IDLE or OVER. startEdge in SERVE or PLAY is ignored.
- Reset, including mid-game: next state IDLE, score=0x00, lives=LIVES, counter=0, ballLoad=0, gameOver=0, start_d=1.

## Timing
- widgetEn is combinational from tick, pause and the state register, so gated widgets move on exactly the tick cycles.
- ballLoad is registered. It is high for exactly one cycle, the cycle after the triggering event (startEdge or non-final miss), which is also the first cycle of the new state.
- state, score, lives and gameOver are registered and change one cycle after the causing input.
- The serve hold lasts exactly SERVE_TICKS unpaused ticks. The first PLAY-enabled tick is the next unpaused tick after the final SERVE tick.
- A miss is counted at most once per ball, because the state leaves PLAY on the same edge.
- Reset to first possible ballLoad: one cycle after startEdge.

## Test plan
- **Reset and start:** Use SERVE_TICKS=3, LIVES=3. Assert Reset for 2 cycles with start held high, then release start and press it again. Expected: no ballLoad while start is held, since start_d resets to 1. After the fresh press: state 0→1, ballLoad high exactly 1 cycle, score=0x00, lives=3.
- **Serve hold and pause:** Issue 3 ticks with pause held during the 2nd. Expected: the counter freezes while paused, state stays SERVE through 3 unpaused ticks then becomes PLAY, and widgetEn stays 0 throughout SERVE.
- **Score:** In PLAY, send 10 hit pulses → score=0x10. Preload to 0x98, then 2 hits → 0x99 and it stays 0x99.
- **Miss:** With ballX=770 and ballSizeX=14 (sum 784) on a tick → lives 3→2, state SERVE, one ballLoad pulse. With ballX=-5 → no miss. With sum exactly 780 → no miss.
- **Game over and restart:** Take lives to 1, then a miss → lives=0, state OVER, gameOver=1, score held. Then a startEdge → SERVE, lives=3, score=0x00.
- **Simultaneous events and mid-game reset:** hit and miss on the same tick → score unchanged, lives decremented. Reset asserted during PLAY → IDLE next cycle with all outputs at their reset values.
